// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding and default width.
// FIX exists only in the DIV_SIGNED_EN build, where it applies the result signs.
package div_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
`ifdef DIV_SIGNED_EN
    ,
    FIX  = 2'd3
`endif
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, compare against the divisor, and subtract when it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] r_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] r_o,
  output logic             q_o
);

  logic [WIDTH:0] r_shift;

  // The incoming remainder is always below the divisor, so the shifted value
  // fits in WIDTH+1 bits and the difference always fits back in WIDTH bits.
  assign r_shift = {r_i, bit_i};
  assign q_o     = (r_shift >= {1'b0, divisor_i});
  assign r_o     = q_o ? WIDTH'(r_shift - {1'b0, divisor_i}) : r_shift[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider: 2W-bit dividend / W-bit divisor -> W-bit quotient and
// remainder, one quotient bit per clock. Define DIV_SIGNED_EN for two's-complement operands.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_zero,
  output logic               overflow
);

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   dlo_q, dlo_d;
  logic [WIDTH-1:0]   dsr_q, dsr_d;
  logic [WIDTH-1:0]   r_q, r_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               dz_q, dz_d;
  logic               ov_q, ov_d;

  logic [2*WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0]   dsr_mag;
  logic [WIDTH-1:0]   step_r;
  logic               step_q;

`ifdef DIV_SIGNED_EN
  localparam logic [WIDTH-1:0] MIN_MAG = {1'b1, {(WIDTH-1){1'b0}}};

  logic qneg_q, qneg_d;
  logic rneg_q, rneg_d;

  // The core always works on magnitudes; signs are re-applied in FIX.
  assign dvd_mag = dividend[2*WIDTH-1] ? -dividend : dividend;
  assign dsr_mag = divisor[WIDTH-1]    ? -divisor  : divisor;
`else
  assign dvd_mag = dividend;
  assign dsr_mag = divisor;
`endif

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .r_i       (r_q),
    .divisor_i (dsr_q),
    .bit_i     (dlo_q[cnt_q]),
    .r_o       (step_r),
    .q_o       (step_q)
  );

  always_comb begin
    state_d = state_q;
    dlo_d   = dlo_q;
    dsr_d   = dsr_q;
    r_d     = r_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    ov_d    = ov_q;
`ifdef DIV_SIGNED_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          dz_d   = 1'b0;
          ov_d   = 1'b0;
          dlo_d  = dvd_mag[WIDTH-1:0];
          dsr_d  = dsr_mag;
`ifdef DIV_SIGNED_EN
          qneg_d = dividend[2*WIDTH-1] ^ divisor[WIDTH-1];
          rneg_d = dividend[2*WIDTH-1];
`endif
          if (divisor == '0) begin
            dz_d    = 1'b1;
            quot_d  = '1;
            rem_d   = dividend[WIDTH-1:0];
            state_d = DONE;
          end else if (dvd_mag[2*WIDTH-1:WIDTH] >= dsr_mag) begin
            // Upper half already >= divisor: quotient needs more than WIDTH bits.
            ov_d    = 1'b1;
            quot_d  = '1;
            rem_d   = dividend[WIDTH-1:0];
            state_d = DONE;
          end else begin
            r_d     = dvd_mag[2*WIDTH-1:WIDTH];
            quot_d  = '0;
            cnt_d   = CNT_INIT;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        r_d    = step_r;
        quot_d = {quot_q[WIDTH-2:0], step_q};
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          rem_d   = step_r;
`ifdef DIV_SIGNED_EN
          state_d = FIX;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef DIV_SIGNED_EN
      FIX: begin
        rem_d = rneg_q ? -rem_q : rem_q;
        if (qneg_q) begin
          if (quot_q > MIN_MAG) begin
            ov_d   = 1'b1;
            quot_d = '1;
          end else begin
            quot_d = -quot_q;
          end
        end else if (quot_q[WIDTH-1]) begin
          ov_d   = 1'b1;
          quot_d = '1;
        end
        state_d = DONE;
      end
`endif
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      ov_q    <= ov_d;
    end
  end

  // Working operands need no reset: they are always loaded on accept.
  always_ff @(posedge clk) begin
    dlo_q  <= dlo_d;
    dsr_q  <= dsr_d;
    r_q    <= r_d;
    cnt_q  <= cnt_d;
`ifdef DIV_SIGNED_EN
    qneg_q <= qneg_d;
    rneg_q <= rneg_d;
`endif
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign div_zero  = dz_q;
  assign overflow  = ov_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases plus randomized operations
// compared against a plain-arithmetic reference model.
module tb_seq_divider;

  localparam int W = 32;
`ifdef DIV_SIGNED_EN
  localparam int LAT = W + 2;
`else
  localparam int LAT = W + 1;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic           in_ready, out_valid, div_zero, overflow;
  logic [2*W-1:0] dividend = '0;
  logic [W-1:0]   divisor = '0;
  logic [W-1:0]   quotient, remainder;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] q_obs, r_obs;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .overflow  (overflow)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [63:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r,
                       output logic dz, output logic ov, output int lat);
    logic [63:0] qq, rr, ma, mb;
    longint sa, sb, sq, sr;
    dz = 1'b0; ov = 1'b0; lat = LAT; q = '0; r = '0;
    qq = '0; rr = '0; ma = '0; mb = '0; sa = 0; sb = 0; sq = 0; sr = 0;
    if (b == 32'd0) begin
      dz = 1'b1; q = '1; r = a[31:0]; lat = 1;
    end else begin
`ifdef DIV_SIGNED_EN
      sa = $signed(a);
      sb = longint'($signed(b));
      ma = (sa < 0) ? 64'(-sa) : 64'(sa);
      mb = (sb < 0) ? 64'(-sb) : 64'(sb);
      if ((ma >> 32) >= mb) begin
        ov = 1'b1; q = '1; r = a[31:0]; lat = 1;
      end else begin
        sq = sa / sb;
        sr = sa % sb;
        r  = sr[31:0];
        if (sq > 64'sd2147483647 || sq < -64'sd2147483648) begin
          ov = 1'b1; q = '1;
        end else begin
          q = sq[31:0];
        end
      end
`else
      qq = a / {32'd0, b};
      rr = a % {32'd0, b};
      if ((qq >> 32) != 64'd0) begin
        ov = 1'b1; q = '1; r = a[31:0]; lat = 1;
      end else begin
        q = qq[31:0]; r = rr[31:0];
      end
`endif
    end
  endtask

  task automatic run_op(input logic [63:0] a, input logic [31:0] b, input int hold, input bit noise);
    logic [31:0] eq, er;
    logic edz, eov;
    int elat, n;
    model(a, b, eq, er, edz, eov, elat);
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    check("in_ready_before_op", 64'(in_ready), 64'd1);
    dividend = a; divisor = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = noise;
    if (noise) begin dividend = ~a; divisor = b + 32'd3; end
    n = 1;
    while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
    in_valid = 1'b0;
    check("latency", 64'(n), 64'(elat));
    check("quotient", 64'(quotient), 64'(eq));
    check("remainder", 64'(remainder), 64'(er));
    check("div_zero", 64'(div_zero), 64'(edz));
    check("overflow", 64'(overflow), 64'(eov));
    q_obs = quotient; r_obs = remainder;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_out_valid", 64'(out_valid), 64'd1);
      check("hold_in_ready", 64'(in_ready), 64'd0);
      check("hold_quotient", 64'(quotient), 64'(eq));
      check("hold_remainder", 64'(remainder), 64'(er));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_in_ready", 64'(in_ready), 64'd1);
    check("release_out_valid", 64'(out_valid), 64'd0);
  endtask

  initial begin
    logic [31:0] b, ahi;
    logic [63:0] a;
    bit seen;

    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_quotient", 64'(quotient), 64'd0);
    check("reset_remainder", 64'(remainder), 64'd0);
    check("reset_flags", 64'({div_zero, overflow}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(64'd100, 32'd7, 0, 1'b0);
    check("100div7_q", 64'(q_obs), 64'd14);
    check("100div7_r", 64'(r_obs), 64'd2);

`ifndef DIV_SIGNED_EN
    run_op(64'd16595372448606846976, 32'd4073741824, 0, 1'b0);
    check("roundtrip_q", 64'(q_obs), 64'd4073741824);
    check("roundtrip_r", 64'(r_obs), 64'd0);
`endif

    run_op(64'd5, 32'd0, 0, 1'b0);
    check("divzero_q", 64'(q_obs), 64'hFFFF_FFFF);
    check("divzero_r", 64'(r_obs), 64'd5);

    run_op(64'h0000_0001_0000_0000, 32'd1, 0, 1'b0);
    check("overflow_q", 64'(q_obs), 64'hFFFF_FFFF);

    run_op(64'h0000_0000_1234_5678, 32'd1000, 5, 1'b1);

    // Reset asserted for one edge during the 10th CALC cycle
    dividend = 64'd100; divisor = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_result", 64'(seen), 64'd0);

    for (int k = 0; k < 24; k++) begin
      b = $urandom;
      if (k % 4 == 0) b = b >> $urandom_range(8, 28);
      if (b == 32'd0) b = 32'd1;
      if (k % 6 == 5) b = 32'd0;
      ahi = $urandom;
      if (k % 7 != 3 && b != 32'd0) ahi = ahi % b;
      a = {ahi, 32'($urandom)};
      run_op(a, b, $urandom_range(0, 2), bit'(k % 2));
    end

`ifdef DIV_SIGNED_EN
    run_op(64'hFFFF_FFFF_FFFF_FF9C, 32'd7, 0, 1'b0);
    check("neg100div7_q", 64'(q_obs), 64'hFFFF_FFF2);
    check("neg100div7_r", 64'(r_obs), 64'hFFFF_FFFE);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
